// File: rtl/replica_pkg.sv
// Shared types and widths for the anneal sequencer and its timer.
// SEQ_TIMEOUT_EN widens the shared timer so it can double as the handshake watchdog.
package replica_pkg;

    localparam int ITER_W      = 32;
    localparam int OPT_W       = 8;
    localparam int EXP_W       = 5;
    localparam int SEQ_TIMEOUT = 65535;
    localparam int WDOG_W      = 16;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMR_W = WDOG_W;
`else
    localparam int TMR_W = (OPT_W > EXP_W) ? OPT_W : EXP_W;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPT,
        S_DELTA,
        S_EXP_INIT,
        S_EXP_RUN,
        S_EXP_FIN,
        S_EXCH,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag, shared by the OPT and EXP_RUN phases
// and, with SEQ_TIMEOUT_EN, by the DELTA/EXCH watchdog.
module seq_timer
    import replica_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is updated with <= only, so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/anneal_sequencer.sv
// Annealing iteration controller: OPT -> DELTA -> EXP_INIT/RUN/FIN -> EXCH per iteration.
// Define SEQ_TIMEOUT_EN to enable the 65535-cycle handshake watchdog and sticky err.
module anneal_sequencer
    import replica_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] iter_num,
    input  logic [OPT_W-1:0]  opt_len,
    input  logic [EXP_W-1:0]  exp_len,
    input  logic              delta_ack,
    input  logic              exch_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              opt_run,
    output logic              delta_req,
    output logic              exp_init,
    output logic              exp_run,
    output logic              exp_fin,
    output logic              exch_req,
    output logic              exch_odd
);

    seq_state_t r_state, w_next;

    logic [ITER_W-1:0] r_iter_num;
    logic [OPT_W-1:0]  r_opt_len;
    logic [EXP_W-1:0]  r_exp_len;
    logic [ITER_W-1:0] r_iter_cnt;
    logic              r_odd;
    logic              r_abort_pend;
    logic              r_busy, r_done, r_opt_run, r_delta_req;
    logic              r_exp_init, r_exp_run, r_exp_fin, r_exch_req;

    logic              w_start_ok;
    logic              w_iter_inc;
    logic              w_abort_any;
    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TMR_W-1:0] WDOG_LOAD = TMR_W'(SEQ_TIMEOUT - 1);
    logic w_timeout;
    logic r_err;
`endif

    // A zero opt length still runs one opt cycle.
    function automatic logic [TMR_W-1:0] opt_load(input logic [OPT_W-1:0] len);
        return (len == '0) ? '0 : TMR_W'(len - OPT_W'(1));
    endfunction

    seq_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    assign w_abort_any = r_abort_pend || abort;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_iter_inc = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_dec  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        w_timeout  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    if (iter_num == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_OPT;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = opt_load(opt_len);
                    end
                end
            end
            S_OPT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_tmr_zero) begin
                    w_next = S_DELTA;
`ifdef SEQ_TIMEOUT_EN
                    w_tmr_load = 1'b1;
                    w_tmr_val  = WDOG_LOAD;
`endif
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            S_DELTA: begin
                if (delta_ack) begin
                    w_next = w_abort_any ? S_IDLE : S_EXP_INIT;
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (w_tmr_zero) begin
                        w_timeout = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
`endif
                end
            end
            S_EXP_INIT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_exp_len == '0) begin
                    w_next = S_EXP_FIN;
                end else begin
                    w_next     = S_EXP_RUN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(r_exp_len - EXP_W'(1));
                end
            end
            S_EXP_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_tmr_zero) begin
                    w_next = S_EXP_FIN;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            S_EXP_FIN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_EXCH;
`ifdef SEQ_TIMEOUT_EN
                    w_tmr_load = 1'b1;
                    w_tmr_val  = WDOG_LOAD;
`endif
                end
            end
            S_EXCH: begin
                if (exch_ack) begin
                    w_iter_inc = 1'b1;
                    if (w_abort_any) begin
                        w_next = S_IDLE;
                    end else if ((r_iter_cnt + ITER_W'(1)) == r_iter_num) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_OPT;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = opt_load(r_opt_len);
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (w_tmr_zero) begin
                        w_timeout = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
`endif
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_iter_num   <= '0;
            r_opt_len    <= '0;
            r_exp_len    <= '0;
            r_iter_cnt   <= '0;
            r_odd        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_opt_run    <= 1'b0;
            r_delta_req  <= 1'b0;
            r_exp_init   <= 1'b0;
            r_exp_run    <= 1'b0;
            r_exp_fin    <= 1'b0;
            r_exch_req   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_opt_run   <= (w_next == S_OPT);
            r_delta_req <= (w_next == S_DELTA);
            r_exp_init  <= (w_next == S_EXP_INIT);
            r_exp_run   <= (w_next == S_EXP_RUN);
            r_exp_fin   <= (w_next == S_EXP_FIN);
            r_exch_req  <= (w_next == S_EXCH);

            if (w_start_ok) begin
                r_iter_num   <= iter_num;
                r_opt_len    <= opt_len;
                r_exp_len    <= exp_len;
                r_iter_cnt   <= '0;
                r_odd        <= 1'b0;
                r_abort_pend <= 1'b0;
            end else begin
                if (w_iter_inc) begin
                    r_iter_cnt <= r_iter_cnt + ITER_W'(1);
                    r_odd      <= ~r_odd;
                end
                // Handshake phases finish their transfer before honouring abort.
                if (abort && ((r_state == S_DELTA) || (r_state == S_EXCH))) begin
                    r_abort_pend <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign iter_cnt  = r_iter_cnt;
    assign opt_run   = r_opt_run;
    assign delta_req = r_delta_req;
    assign exp_init  = r_exp_init;
    assign exp_run   = r_exp_run;
    assign exp_fin   = r_exp_fin;
    assign exch_req  = r_exch_req;
    assign exch_odd  = r_odd;

endmodule

// File: doc/anneal_sequencer.md
# anneal_sequencer

Top-level iteration controller for the replica node array. Runs the annealing loop for a programmed number of iterations. Each iteration has four phases, in order: opt run, delta-distance evaluation, exp evaluation, and replica exchange. It drives the broadcast control strobes shared by all nodes and uses req/ack handshakes for the variable-latency phases.

## Interface
- ITER_W, 32, width of iteration count
- OPT_W, 8, width of opt-run length
- EXP_W, 5, width of exp-run length
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a run when idle
- abort  in  1  level; stops the run (see Operation)
- iter_num  in  ITER_W  iterations to perform; sampled at start
- opt_len  in  OPT_W  opt_run cycles per iteration; sampled at start
- exp_len  in  EXP_W  exp_run cycles per iteration; sampled at start
- delta_ack  in  1  delta-distance datapath finished
- exch_ack  in  1  exchange datapath finished
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky watchdog error (only with SEQ_TIMEOUT_EN)
- iter_cnt  out  ITER_W  completed iterations
- opt_run  out  1  broadcast opt enable
- delta_req  out  1  delta-distance request (level)
- exp_init, exp_run, exp_fin  out  1 each  exp unit strobes
- exch_req  out  1  exchange request (level)
- exch_odd  out  1  exchange pairing: 0 = even pairs, 1 = odd pairs

## Operation
- States: IDLE, OPT, DELTA, EXP_INIT, EXP_RUN, EXP_FIN, EXCH, DONE.
- IDLE + start:
  - Latch iter_num, opt_len, exp_len.
  - Clear iter_cnt, exch_odd, and err.
  - If iter_num==0, go to DONE; otherwise go to OPT.
- OPT: opt_run=1 for max(opt_len,1) cycles, then go to DELTA.
- DELTA: delta_req=1 until delta_ack is sampled high, then go to EXP_INIT.
- EXP_INIT: exp_init=1 for 1 cycle. Go to EXP_RUN, or to EXP_FIN if exp_len==0.
- EXP_RUN: exp_run=1 for exp_len cycles, then go to EXP_FIN.
- EXP_FIN: exp_fin=1 for 1 cycle, then go to EXCH.
- EXCH: exch_req=1 until exch_ack is sampled high. On ack:
  - iter_cnt increments.
  - exch_odd toggles.
  - If the new iter_cnt==iter_num, go to DONE; otherwise go to OPT.
- DONE: done=1 for 1 cycle, then go to IDLE.
- start while busy is ignored.
- An ack outside its own wait state is ignored.
- Abort, pending mode:
  - abort high in OPT, EXP_INIT, EXP_RUN, or EXP_FIN goes to IDLE next cycle.
  - All strobes drop. done is not pulsed. iter_cnt is held.
- Abort, handshake mode:
  - abort seen in DELTA or EXCH is latched.
  - The FSM goes to IDLE on the cycle after the matching ack. This never leaves a datapath mid-transfer.
- iter_cnt wraps never: iter_num caps the count.

## Timing
- All outputs are registered. Reset values: state IDLE, all outputs 0, iter_cnt 0.
- start at cycle T gives opt_run high from T+1 through T+opt_len.
- delta_req rises the cycle after the last opt_run cycle.
- delta_req falls the cycle after delta_ack is sampled. If the ack is already high at entry, the request is 1 cycle long.
- Exp strobes are mutually exclusive and contiguous: 1 + exp_len + 1 cycles.
- Fixed phase-transition overhead per iteration: 0 idle cycles between phases.
- Iteration length = opt_len + delta wait + exp_len + 2 + exch wait.
- done pulses one cycle after the final exch_ack.
- With iter_num==0, done pulses at T+1.
- Reset asserted mid-run clears everything immediately (asynchronous). Nothing resumes after reset.

## Configuration
- SEQ_TIMEOUT_EN, defined:
  - A 16-bit wait counter runs in DELTA and EXCH.
  - 65535 cycles without ack sets err (sticky until the next start) and forces IDLE without done.
- SEQ_TIMEOUT_EN, undefined: waits are unbounded, err is tied to 0, and the counter is absent.

## Structure
- replica_pkg holds:
  - seq_state_t enum.
  - Widths ITER_W, OPT_W, EXP_W.
  - SEQ_TIMEOUT constant.
- Sub-module seq_timer:
  - Loadable down-counter with a zero flag.
  - Shared by OPT and EXP_RUN.
  - Reused as the watchdog when SEQ_TIMEOUT_EN is defined.

## Test plan
- Nominal run:
  - Stimulus: iter_num=3, opt_len=4, exp_len=2, acks 2 cycles after req.
  - Response: 3 iterations of 4 opt_run cycles each; exp pattern init/run/run/fin; exch_odd = 0,1,0; done once; iter_cnt=3.
- Zero iterations: iter_num=0 → done at T+1, no strobes, busy high for exactly 1 cycle.
- Edge lengths: opt_len=0, exp_len=0 → 1 opt_run cycle; exp_init directly followed by exp_fin.
- Abort in EXP_RUN of iteration 2 → IDLE next cycle, no done, iter_cnt=1.
- Abort while DELTA waits → delta_req held until ack, then IDLE; start is ignored while busy.
- SEQ_TIMEOUT_EN, exch_ack never asserted → err after 65535 cycles, IDLE, no done; next start clears err.
